uart_int_ctrl: RTL and testbench
================================

UART_INT_CTRL -- requirements
Module: uart_int_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 640, meaning baud pulses without RX FIFO activity before a character timeout (4 chars x 10 bits x 16).
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge; rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: wr_i in 1 host write strobe; rd_i in 1 host read strobe; addr_i in 3 register address; din_i in 8 write data; dlab_i in 1 LCR divisor-latch access bit.
REQ-004 SHALL have ports: fifo_en_i in 1 FCR FIFO enable; rx_fifo_count_i in 5 RX FIFO occupancy (0-16); rx_fifo_threshold_i in 4 RX trigger level; rx_push_i in 1 character written into RX FIFO; rx_pop_i in 1 character read from RX FIFO.
REQ-005 SHALL have ports: lsr_err_i in 1 OR of LSR oe/pe/fe/bi; tx_fifo_empty_i in 1 TX FIFO empty; baud_pulse_i in 1 baud tick.
REQ-006 SHALL have ports: ier_o out 8 Interrupt Enable Register; iir_o out 8 Interrupt Identification Register; irq_o out 1 interrupt request.

Function
REQ-007 SHALL write IER when wr_i=1, addr_i=1, dlab_i=0: ier[3:0] <= din_i[3:0]; ier_o = {4'b0000, ier[3:0]}; bit0 ERBFI, bit1 ETBEI, bit2 ELSI, bit3 EDSSI (stored only, no source).
REQ-008 SHALL hold line-status pending ls_pend: set when lsr_err_i=1; cleared on LSR read (rd_i=1, addr_i=5); set wins if both occur in the same cycle.
REQ-009 SHALL derive rx_avail combinationally: fifo_en_i=1 -> rx_fifo_count_i >= rx_fifo_threshold_i and count != 0; fifo_en_i=0 -> count != 0.
REQ-010 SHALL hold THRE pending thre_pend: set on rising edge of tx_fifo_empty_i (registered previous value), or on an IER write changing ETBEI 0->1 while tx_fifo_empty_i=1; cleared on THR write (wr_i=1, addr_i=0, dlab_i=0) or on IIR read (rd_i=1, addr_i=2) while iir_o[3:0]=4'b0010; set wins over clear in the same cycle.
REQ-011 SHALL compute iir_o[3:0] combinationally from pending flags masked by IER, fixed priority: ls_pend&ELSI -> 0110; rx_avail&ERBFI -> 0100; to_pend&ERBFI -> 1100; thre_pend&ETBEI -> 0010; none -> 0001.
REQ-012 SHALL drive iir_o[5:4]=00 and iir_o[7:6]=11 when fifo_en_i=1, else 00.
REQ-013 SHALL drive irq_o = ~iir_o[0].
REQ-014 SHALL reflect a pending-flag change in iir_o/irq_o in the cycle after the clock edge that sampled the event (one-cycle latency); IER writes take effect the same way.
REQ-015 SHALL ignore wr_i/rd_i at addresses 1 and 0 when dlab_i=1 (divisor latch access).

Reset
REQ-016 SHALL on rst=1 at a clock edge clear ier, ls_pend, thre_pend, to_pend, timeout counter, and previous tx_fifo_empty_i sample, giving ier_o=8'h00, iir_o=8'h01, irq_o=0 in the following cycle.
REQ-017 SHALL give rst priority over all writes, reads and events in the same cycle, including mid-timeout count.

Configuration
REQ-018 SHALL, with UART_INT_TIMEOUT_EN defined, include timeout counter: clears on rx_push_i, rx_pop_i, or fifo_en_i=0 or rx_fifo_count_i=0; otherwise increments on baud_pulse_i, saturating at TIMEOUT_TICKS; to_pend = (counter == TIMEOUT_TICKS), so cleared by the next pop/push.
REQ-019 SHALL, without UART_INT_TIMEOUT_EN, omit the counter, tie to_pend=0, and never report 1100.

Verification
REQ-020 SHALL cover: rst, then read -> ier_o=00, iir_o=01, irq_o=0.
REQ-021 SHALL cover: IER=01, fifo_en_i=1, threshold=4, count 3->4 -> iir_o=C4, irq_o=1; count 4->3 -> iir_o=C1.
REQ-022 SHALL cover: IER=07, lsr_err_i pulse with rx_avail and thre_pend pending -> iir_o[3:0]=6; LSR read -> 4; pop to count=0 -> 2; IIR read -> 1.
REQ-023 SHALL cover: tx_fifo_empty_i=1, IER write 02 -> iir_o=02 next cycle; THR write -> iir_o=01; tx_fifo_empty_i 0->1 -> 02 again.
REQ-024 SHALL cover (macro defined, TIMEOUT_TICKS=8): IER=01, threshold=8, count=2, 8 baud pulses idle -> iir_o=CC; rx_pop_i -> to_pend clears; rx_push_i at pulse 7 restarts count.
REQ-025 SHALL cover: rst asserted in same cycle as IER write 0F and lsr_err_i=1 -> ier_o=00, iir_o=01.

Source files
------------

// File: rtl/uart_int_ctrl.sv
// ---------------------------------------------------------------------------
// uart_int_ctrl
//
// Interrupt controller for a 16550-style UART. It holds the Interrupt Enable
// Register, tracks the pending interrupt sources, and presents the
// prioritised Interrupt Identification Register and the interrupt request.
//
// Optional feature macro: UART_INT_TIMEOUT_EN
//   Defined   -> an RX character-timeout counter is built. It raises the
//                timeout source (IIR id 1100) after TIMEOUT_TICKS idle baud
//                pulses while the RX FIFO holds data.
//   Undefined -> no counter. The timeout source is tied off and id 1100 is
//                never reported.
//
// Ports
//   clk                 : single clock; all logic on the rising edge
//   rst                 : synchronous, active-high reset
//   wr_i / rd_i         : host write / read strobes
//   addr_i[2:0]         : register address
//   din_i[7:0]          : host write data
//   dlab_i              : LCR divisor-latch access bit
//   fifo_en_i           : FCR FIFO enable
//   rx_fifo_count_i     : RX FIFO occupancy (0-16)
//   rx_fifo_threshold_i : RX trigger level
//   rx_push_i/rx_pop_i  : character written into / read from the RX FIFO
//   lsr_err_i           : OR of the LSR overrun/parity/framing/break bits
//   tx_fifo_empty_i     : TX FIFO empty
//   baud_pulse_i        : baud tick
//   ier_o               : Interrupt Enable Register
//   iir_o               : Interrupt Identification Register
//   irq_o               : interrupt request (active-high)
// ---------------------------------------------------------------------------
module uart_int_ctrl #(
   parameter int unsigned TIMEOUT_TICKS = 640
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_i,
   input  logic       rd_i,
   input  logic [2:0] addr_i,
   input  logic [7:0] din_i,
   input  logic       dlab_i,
   input  logic       fifo_en_i,
   input  logic [4:0] rx_fifo_count_i,
   input  logic [3:0] rx_fifo_threshold_i,
   input  logic       rx_push_i,
   input  logic       rx_pop_i,
   input  logic       lsr_err_i,
   input  logic       tx_fifo_empty_i,
   input  logic       baud_pulse_i,
   output logic [7:0] ier_o,
   output logic [7:0] iir_o,
   output logic       irq_o
);

   // Host access decode. Addresses 0 and 1 alias the divisor latch while
   // DLAB is set, so THR/IER accesses are qualified with ~dlab_i.
   logic ier_wr, thr_wr, lsr_rd, iir_rd;

   assign ier_wr = wr_i & (addr_i == 3'd1) & ~dlab_i;
   assign thr_wr = wr_i & (addr_i == 3'd0) & ~dlab_i;
   assign lsr_rd = rd_i & (addr_i == 3'd5);
   assign iir_rd = rd_i & (addr_i == 3'd2);

   logic [3:0] ier_q, ier_d;
   logic       ls_pend_q, ls_pend_d;
   logic       thre_pend_q, thre_pend_d;
   logic       tx_empty_prev_q;
   logic       rx_avail;
   logic       to_pend;
   logic [3:0] iir_id;

   // Received-data-available follows the FIFO occupancy directly.
   // In FIFO mode, a non-zero count is still required so that a threshold
   // of zero does not raise an interrupt on an empty FIFO.
   always_comb begin
      if (fifo_en_i) begin
         rx_avail = (rx_fifo_count_i >= {1'b0, rx_fifo_threshold_i}) &&
                    (rx_fifo_count_i != 5'd0);
      end else begin
         rx_avail = (rx_fifo_count_i != 5'd0);
      end
   end

`ifdef UART_INT_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_TICKS);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   // Any FIFO activity, or nothing to time out on, restarts the count.
   // Otherwise the counter saturates so that the timeout stays pending
   // until the next push or pop.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (rx_push_i || rx_pop_i || !fifo_en_i || (rx_fifo_count_i == 5'd0)) begin
         to_cnt_d = '0;
      end else if (baud_pulse_i && (to_cnt_q != TO_MAX)) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end

   assign to_pend = (to_cnt_q == TO_MAX);

   logic unused_din;
   assign unused_din = &{1'b0, din_i[7:4]};
`else
   assign to_pend = 1'b0;

   logic unused_in;
   assign unused_in = &{1'b0, din_i[7:4], rx_push_i, rx_pop_i, baud_pulse_i};
`endif

   // Interrupt identification: fixed priority over the enabled sources.
   always_comb begin
      iir_id = 4'b0001;
      if (ls_pend_q && ier_q[2]) begin
         iir_id = 4'b0110;
      end else if (rx_avail && ier_q[0]) begin
         iir_id = 4'b0100;
      end else if (to_pend && ier_q[0]) begin
         iir_id = 4'b1100;
      end else if (thre_pend_q && ier_q[1]) begin
         iir_id = 4'b0010;
      end
   end

   assign iir_o = {(fifo_en_i ? 2'b11 : 2'b00), 2'b00, iir_id};
   assign ier_o = {4'b0000, ier_q};
   assign irq_o = ~iir_o[0];

   // Next-state for the enable register and the pending flags.
   logic thre_set, thre_clr;

   always_comb begin
      ier_d = ier_q;
      if (ier_wr) begin
         ier_d = din_i[3:0];
      end

      // Line-status error: a new error in the same cycle as the LSR read
      // must not be lost, so set dominates clear.
      ls_pend_d = lsr_err_i | (ls_pend_q & ~lsr_rd);

      // THRE fires on the empty edge, or when software enables ETBEI while
      // the TX FIFO is already empty (otherwise no edge would ever come).
      // Reading IIR only acknowledges THRE when THRE is what it reported.
      thre_set = (tx_fifo_empty_i & ~tx_empty_prev_q) |
                 (ier_wr & din_i[1] & ~ier_q[1] & tx_fifo_empty_i);
      thre_clr = thr_wr | (iir_rd & (iir_id == 4'b0010));
      thre_pend_d = thre_set | (thre_pend_q & ~thre_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ier_q           <= 4'b0000;
         ls_pend_q       <= 1'b0;
         thre_pend_q     <= 1'b0;
         tx_empty_prev_q <= 1'b0;
      end else begin
         ier_q           <= ier_d;
         ls_pend_q       <= ls_pend_d;
         thre_pend_q     <= thre_pend_d;
         tx_empty_prev_q <= tx_fifo_empty_i;
      end
   end

endmodule

// File: tb/tb_uart_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_int_ctrl
//
// Self-checking bench for uart_int_ctrl. A behavioural model of the
// interrupt sources (pending flags, idle-baud tally, priority list) predicts
// ier_o/iir_o/irq_o after every clock edge. Directed sequences additionally
// compare against literal register values; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_uart_int_ctrl;

   localparam int TT = 8;
`ifdef UART_INT_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       wr, rd, dlab, fifo_en, push, pop, lsr_err, tx_empty, baud;
   logic [2:0] addr;
   logic [7:0] din;
   logic [4:0] cnt;
   logic [3:0] thr;
   logic [7:0] ier, iir;
   logic       irq;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_int_ctrl #(.TIMEOUT_TICKS(TT)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .wr_i                (wr),
      .rd_i                (rd),
      .addr_i              (addr),
      .din_i               (din),
      .dlab_i              (dlab),
      .fifo_en_i           (fifo_en),
      .rx_fifo_count_i     (cnt),
      .rx_fifo_threshold_i (thr),
      .rx_push_i           (push),
      .rx_pop_i            (pop),
      .lsr_err_i           (lsr_err),
      .tx_fifo_empty_i     (tx_empty),
      .baud_pulse_i        (baud),
      .ier_o               (ier),
      .iir_o               (iir),
      .irq_o               (irq)
   );

   // Reference model state
   logic [3:0] m_ier;
   bit         m_ls, m_thre, m_prev_empty;
   int         m_idle;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_iir();
      bit rx_av, to;
      logic [3:0] id;
      rx_av = fifo_en ? ((int'(cnt) >= int'(thr)) && (cnt != 0)) : (cnt != 0);
      to    = TO_ON && (m_idle == TT);
      if      (m_ls  && m_ier[2]) id = 4'h6;
      else if (rx_av && m_ier[0]) id = 4'h4;
      else if (to    && m_ier[0]) id = 4'hC;
      else if (m_thre && m_ier[1]) id = 4'h2;
      else                         id = 4'h1;
      return {(fifo_en ? 4'hC : 4'h0), id};
   endfunction

   task automatic model_step();
      logic [7:0] cur;
      bit ier_w, thre_set, thre_clr;
      if (rst) begin
         m_ier = 4'h0; m_ls = 0; m_thre = 0; m_prev_empty = 0; m_idle = 0;
      end else begin
         cur      = model_iir();
         ier_w    = wr && addr == 3'd1 && !dlab;
         thre_set = (tx_empty && !m_prev_empty) || (ier_w && din[1] && !m_ier[1] && tx_empty);
         thre_clr = (wr && addr == 3'd0 && !dlab) || (rd && addr == 3'd2 && cur[3:0] == 4'h2);
         m_thre   = thre_set || (m_thre && !thre_clr);
         m_ls     = lsr_err || (m_ls && !(rd && addr == 3'd5));
         if (push || pop || !fifo_en || cnt == 0) m_idle = 0;
         else if (baud && m_idle < TT)            m_idle = m_idle + 1;
         m_prev_empty = tx_empty;
         if (ier_w) m_ier = din[3:0];
      end
   endtask

   task automatic cmp_model();
      logic [7:0] e;
      e = model_iir();
      check_eq("m_iir", iir, e);
      check_eq("m_irq", {7'd0, irq}, {7'd0, ~e[0]});
      check_eq("m_ier", ier, {4'h0, m_ier});
   endtask

   // One clock: model sees the same inputs the DUT samples, then compare.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cmp_model();
   endtask

   task automatic strobes_off();
      wr = 0; rd = 0; push = 0; pop = 0; lsr_err = 0; baud = 0; rst = 0;
   endtask

   task automatic do_reset();
      strobes_off();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
      wr = 1; addr = a; din = d;
      tick();
      wr = 0;
   endtask

   task automatic host_rd(input logic [2:0] a);
      rd = 1; addr = a;
      tick();
      rd = 0;
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         baud = 1; tick();
         baud = 0; tick();
      end
   endtask

   initial begin
      strobes_off();
      addr = 0; din = 0; dlab = 0; fifo_en = 0; cnt = 0; thr = 0; tx_empty = 0;
      m_ier = 0; m_ls = 0; m_thre = 0; m_prev_empty = 0; m_idle = 0;
      #2;

      // Reset state
      do_reset();
      #1;
      check_eq("rst_ier", ier, 8'h00);
      check_eq("rst_iir", iir, 8'h01);
      check_eq("rst_irq", {7'd0, irq}, 8'h00);

      // RX threshold in FIFO mode
      host_wr(3'd1, 8'h01);
      fifo_en = 1; thr = 4; cnt = 3; #1;
      check_eq("rx_below", iir, 8'hC1);
      cnt = 4; #1;
      check_eq("rx_at", iir, 8'hC4);
      check_eq("rx_irq", {7'd0, irq}, 8'h01);
      cnt = 3; #1;
      check_eq("rx_drop", iir, 8'hC1);

      // Priority walk-down
      host_wr(3'd1, 8'h07);
      tx_empty = 1; tick();
      cnt = 4; #1;
      check_eq("pri_rx", iir, 8'hC4);
      lsr_err = 1; #1;
      check_eq("ls_latency", iir, 8'hC4);
      tick(); lsr_err = 0; #1;
      check_eq("pri_ls", iir, 8'hC6);
      host_rd(3'd5); #1;
      check_eq("lsr_rd", iir, 8'hC4);
      cnt = 0; #1;
      check_eq("pri_thre", iir, 8'hC2);
      host_rd(3'd2); #1;
      check_eq("iir_rd", iir, 8'hC1);

      // THRE via ETBEI enable, THR write, empty edge, DLAB aliasing
      fifo_en = 0; cnt = 0; tx_empty = 1;
      do_reset();
      tick();
      host_wr(3'd0, 8'h55); #1;
      check_eq("thre_none", iir, 8'h01);
      host_wr(3'd1, 8'h02); #1;
      check_eq("etbei_set", iir, 8'h02);
      dlab = 1;
      host_wr(3'd0, 8'hAA);
      host_wr(3'd1, 8'h00);
      dlab = 0; #1;
      check_eq("dlab_thr", iir, 8'h02);
      check_eq("dlab_ier", ier, 8'h02);
      host_wr(3'd0, 8'h55); #1;
      check_eq("thr_clr", iir, 8'h01);
      tx_empty = 0; tick();
      tx_empty = 1; tick(); #1;
      check_eq("empty_edge", iir, 8'h02);

      // Character timeout
      tx_empty = 0; fifo_en = 1; thr = 8; cnt = 2;
      do_reset();
      host_wr(3'd1, 8'h01);
      pulses(7); #1;
      check_eq("to_7", iir, 8'hC1);
      pulses(1); #1;
      check_eq("to_8", iir, TO_ON ? 8'hCC : 8'hC1);
      pulses(3); #1;
      check_eq("to_sat", iir, TO_ON ? 8'hCC : 8'hC1);
      pop = 1; tick(); pop = 0; #1;
      check_eq("to_pop", iir, 8'hC1);
      pulses(6);
      baud = 1; push = 1; tick(); baud = 0; push = 0; tick();
      pulses(7); #1;
      check_eq("to_restart", iir, 8'hC1);
      pulses(1); #1;
      check_eq("to_again", iir, TO_ON ? 8'hCC : 8'hC1);

      // Reset beats simultaneous write and error, mid-count
      pulses(3);
      fifo_en = 0;
      rst = 1; wr = 1; addr = 3'd1; din = 8'h0F; lsr_err = 1;
      tick();
      strobes_off(); #1;
      check_eq("rst_pri_ier", ier, 8'h00);
      check_eq("rst_pri_iir", iir, 8'h01);

      // Randomized phase
      for (int i = 0; i < 3000; i++) begin
         rst     = ($urandom_range(0, 199) == 0);
         wr      = ($urandom_range(0, 5) == 0);
         rd      = ($urandom_range(0, 4) == 0);
         addr    = 3'($urandom_range(0, 7));
         din     = 8'($urandom);
         dlab    = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 31) == 0) fifo_en = ~fifo_en;
         if ($urandom_range(0, 15) == 0) cnt = 5'($urandom_range(0, 16));
         if ($urandom_range(0, 31) == 0) thr = 4'($urandom_range(0, 15));
         push    = ($urandom_range(0, 29) == 0);
         pop     = ($urandom_range(0, 29) == 0);
         lsr_err = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 9) == 0) tx_empty = ~tx_empty;
         baud    = ($urandom_range(0, 1) == 0);
         #1;
         cmp_model();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
